// File: rtl/dbus_ctrl.sv
// dbus_ctrl: data-bus controller between the CPU data port and up to
// NUM_SLAVES slaves. One access at a time runs through IDLE -> ACCESS -> DONE.
// Outputs are derived from the state register and the request latched in IDLE.
// The top SEL_BITS address bits select the slave. An unmapped index skips
// ACCESS and completes with o_err.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req/i_we        CPU request (held until o_ready), write enable
//   i_addr/i_wdata    CPU address and write data
//   o_rdata/o_ready   read data and one-cycle completion pulse
//   o_err             unmapped access (or slave timeout), valid with o_ready
//   o_sel/o_we        one-hot slave select, single-cycle slave write strobe
//   o_addr/o_wdata    slave-local address and write data
//   i_rdata           packed slave read data, slave k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_wait            per-slave stall request (only with DBUS_SLAVE_WAIT_EN)
//
// Optional feature macro: DBUS_SLAVE_WAIT_EN. When it is defined, the i_wait
// port and the TIMEOUT parameter are added. A slave can then extend ACCESS
// after the wait states. A stall lasting TIMEOUT cycles ends the access with
// o_err.
//
// state  | meaning
// IDLE   | waiting for i_req; latches the request
// ACCESS | slave selected; counts wait states (and slave stalls)
// DONE   | o_ready pulse; o_err for unmapped or timed-out access

module dbus_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int NUM_SLAVES  = 3,
    parameter int SEL_BITS    = 2,
    parameter int WAIT_STATES = 1
`ifdef DBUS_SLAVE_WAIT_EN
    ,
    parameter int TIMEOUT     = 15
`endif
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_req,
    input  logic                             i_we,
    input  logic [ADDR_WIDTH-1:0]            i_addr,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic                             o_ready,
    output logic                             o_err,
    output logic [NUM_SLAVES-1:0]            o_sel,
    output logic                             o_we,
    output logic [ADDR_WIDTH-SEL_BITS-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]            o_wdata,
`ifdef DBUS_SLAVE_WAIT_EN
    input  logic [NUM_SLAVES-1:0]            i_wait,
`endif
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_rdata
);

    localparam int LADDR_W = ADDR_WIDTH - SEL_BITS;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic                  we_q;
    logic [LADDR_W-1:0]    addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SEL_BITS-1:0]   idx_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [7:0]            cnt_q;

    logic [SEL_BITS-1:0]   idx_in;
    logic                  mapped_in;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic                  stall;
    logic                  timeout_hit;
    logic                  last_cycle;

    assign idx_in    = i_addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign mapped_in = (int'(idx_in) < NUM_SLAVES);

    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SEL_BITS'(k)) rdata_sel = i_rdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef DBUS_SLAVE_WAIT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q;
    logic               wait_sel;

    always_comb begin
        wait_sel = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SEL_BITS'(k)) wait_sel = i_wait[k];
        end
    end

    // A stall only counts once the fixed wait states are used up.
    assign stall       = (state_q == ACCESS) && (cnt_q == 8'd0) && wait_sel;
    assign timeout_hit = stall && (stall_q == STALL_W'(TIMEOUT - 1));
`else
    assign stall       = 1'b0;
    assign timeout_hit = 1'b0;
`endif

    // Final ACCESS cycle of a normal (non-timed-out) transfer.
    assign last_cycle = (state_q == ACCESS) && (cnt_q == 8'd0) && !stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req) state_d = mapped_in ? ACCESS : DONE;
            ACCESS:  if (last_cycle || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == DONE);
        o_err   = (state_q == DONE) && err_q;
        o_rdata = (state_q == DONE) ? rdata_q : '0;
        o_sel   = '0;
        o_addr  = '0;
        o_wdata = '0;
        o_we    = last_cycle && we_q;
        if (state_q == ACCESS) begin
            o_addr  = addr_q;
            o_wdata = wdata_q;
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (idx_q == SEL_BITS'(k)) o_sel[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= 8'd0;
`ifdef DBUS_SLAVE_WAIT_EN
            stall_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        we_q    <= i_we;
                        addr_q  <= i_addr[LADDR_W-1:0];
                        wdata_q <= i_wdata;
                        idx_q   <= idx_in;
                        err_q   <= !mapped_in;
                        rdata_q <= '0;
                        cnt_q   <= 8'(WAIT_STATES);
`ifdef DBUS_SLAVE_WAIT_EN
                        stall_q <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
`ifdef DBUS_SLAVE_WAIT_EN
                    else if (stall) begin
                        stall_q <= stall_q + STALL_W'(1);
                    end
`endif
                    else begin
                        rdata_q <= we_q ? '0 : rdata_sel;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Bench for dbus_ctrl: directed scenarios plus randomized accesses. Results are
// compared against an arithmetic model of the access timing and the decode.
module tb_dbus_ctrl;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int NS   = 3;
    localparam int SB   = 2;
    localparam int WS   = 1;
    localparam int LW   = AW - SB;
    localparam int MAXC = 40;

    logic          i_clk = 1'b0;
    logic          i_rst, i_req, i_we;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [DW-1:0] o_rdata;
    logic          o_ready, o_err, o_we;
    logic [NS-1:0] o_sel;
    logic [LW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic [NS*DW-1:0] i_rdata;
`ifdef DBUS_SLAVE_WAIT_EN
    logic [NS-1:0] i_wait;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [NS];
    logic [NS-1:0] obs_sel   [0:MAXC];
    logic          obs_we    [0:MAXC];
    logic          obs_ready [0:MAXC];
    logic          obs_err   [0:MAXC];
    logic [LW-1:0] obs_addr  [0:MAXC];
    logic [DW-1:0] obs_wdata [0:MAXC];
    logic [DW-1:0] obs_rdata [0:MAXC];
    int            ready_at;

    dbus_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS),
        .SEL_BITS(SB), .WAIT_STATES(WS)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
        .o_ready(o_ready), .o_err(o_err), .o_sel(o_sel), .o_we(o_we),
        .o_addr(o_addr), .o_wdata(o_wdata),
`ifdef DBUS_SLAVE_WAIT_EN
        .i_wait(i_wait),
`endif
        .i_rdata(i_rdata)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_mem();
        for (int k = 0; k < NS; k++) begin
            mem[k] = DW'($urandom);
            i_rdata[k*DW +: DW] = mem[k];
        end
    endtask

    // Runs one access. Starts in an IDLE cycle at #1 after an edge. Records the
    // outputs of cycle N+j in index j. Returns in the following IDLE cycle.
    task automatic drive_access(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input bit mutate);
        for (int j = 0; j <= MAXC; j++) begin
            obs_sel[j] = '0; obs_we[j] = 1'b0; obs_ready[j] = 1'b0; obs_err[j] = 1'b0;
            obs_addr[j] = '0; obs_wdata[j] = '0; obs_rdata[j] = '0;
        end
        ready_at = 0;
        i_we = we; i_addr = addr; i_wdata = wdata; i_req = 1'b1;
        @(posedge i_clk); #1;
        for (int j = 1; j <= MAXC; j++) begin
            obs_sel[j] = o_sel; obs_we[j] = o_we; obs_ready[j] = o_ready;
            obs_err[j] = o_err; obs_addr[j] = o_addr; obs_wdata[j] = o_wdata;
            obs_rdata[j] = o_rdata;
            if (o_ready) begin
                ready_at = j;
                break;
            end
            if (mutate) begin
                i_addr = AW'($urandom); i_wdata = DW'($urandom); i_we = 1'($urandom);
            end
            @(posedge i_clk); #1;
        end
        i_req = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_req = 1'b1; i_we = 1'b1;
        i_addr = AW'($urandom); i_wdata = DW'($urandom);
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_ready, o_err, o_rdata, o_sel, o_we, o_addr, o_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b err=%b rd=%h sel=%b we=%b addr=%h wd=%h exp all 0",
                     o_ready, o_err, o_rdata, o_sel, o_we, o_addr, o_wdata);
        end
        i_rst = 1'b0; i_req = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready got %b exp 0", o_ready);
        end
    endtask

    task automatic test_write();
        load_mem();
        drive_access(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        checks++;
        if (ready_at !== 3) begin
            errors++;
            $display("FAIL write_latency got %0d exp 3", ready_at);
        end
        checks++;
        if ({obs_sel[1], obs_sel[2]} !== {3'b001, 3'b001}) begin
            errors++;
            $display("FAIL write_sel got %b/%b exp 001/001", obs_sel[1], obs_sel[2]);
        end
        checks++;
        if (obs_addr[1] !== 14'h0010) begin
            errors++;
            $display("FAIL write_addr got %h exp 0010", obs_addr[1]);
        end
        checks++;
        if (obs_wdata[2] !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_wdata got %h exp beef", obs_wdata[2]);
        end
        checks++;
        if ({obs_we[1], obs_we[2], obs_we[3]} !== 3'b010) begin
            errors++;
            $display("FAIL write_we_pulse got %b%b%b exp 010", obs_we[1], obs_we[2], obs_we[3]);
        end
        checks++;
        if ({obs_ready[3], obs_err[3], obs_rdata[3]} !== {1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL write_done got rdy=%b err=%b rd=%h exp 1 0 0000",
                     obs_ready[3], obs_err[3], obs_rdata[3]);
        end
    endtask

    task automatic test_read();
        load_mem();
        mem[1] = 16'h1234;
        i_rdata[DW +: DW] = 16'h1234;
        drive_access(1'b0, 16'h4020, 16'h0000, 1'b0);
        checks++;
        if (ready_at !== 3) begin
            errors++;
            $display("FAIL read_latency got %0d exp 3", ready_at);
        end
        checks++;
        if ({obs_sel[1], obs_sel[2], obs_sel[3]} !== {3'b010, 3'b010, 3'b000}) begin
            errors++;
            $display("FAIL read_sel got %b/%b/%b exp 010/010/000", obs_sel[1], obs_sel[2], obs_sel[3]);
        end
        checks++;
        if (obs_addr[1] !== 14'h0020) begin
            errors++;
            $display("FAIL read_addr got %h exp 0020", obs_addr[1]);
        end
        checks++;
        if (obs_rdata[3] !== 16'h1234) begin
            errors++;
            $display("FAIL read_rdata got %h exp 1234", obs_rdata[3]);
        end
        checks++;
        if ({obs_we[1], obs_we[2]} !== 2'b00) begin
            errors++;
            $display("FAIL read_we got %b%b exp 00", obs_we[1], obs_we[2]);
        end
    endtask

    task automatic test_unmapped();
        load_mem();
        drive_access(1'b0, 16'hC000, 16'h0000, 1'b0);
        checks++;
        if (ready_at !== 1) begin
            errors++;
            $display("FAIL unmapped_latency got %0d exp 1", ready_at);
        end
        checks++;
        if ({obs_err[1], obs_rdata[1], obs_sel[1], obs_we[1]} !== {1'b1, 16'h0, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL unmapped_done got err=%b rd=%h sel=%b we=%b exp 1 0000 000 0",
                     obs_err[1], obs_rdata[1], obs_sel[1], obs_we[1]);
        end
    endtask

    task automatic test_latch();
        logic [DW-1:0] wd;
        load_mem();
        wd = DW'($urandom);
        drive_access(1'b1, 16'h8ABC, wd, 1'b1);
        checks++;
        if (ready_at !== 3) begin
            errors++;
            $display("FAIL latch_latency got %0d exp 3", ready_at);
        end
        for (int j = 1; j <= 2; j++) begin
            checks++;
            if ({obs_sel[j], obs_addr[j], obs_wdata[j]} !== {3'b100, 14'h0ABC, wd}) begin
                errors++;
                $display("FAIL latch_bus cyc %0d got sel=%b addr=%h wd=%h exp 100 0abc %h",
                         j, obs_sel[j], obs_addr[j], obs_wdata[j], wd);
            end
        end
        checks++;
        if ({obs_we[1], obs_we[2]} !== 2'b01) begin
            errors++;
            $display("FAIL latch_we got %b%b exp 01", obs_we[1], obs_we[2]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_mem();
        i_we = 1'b1; i_addr = 16'h4100; i_wdata = DW'($urandom); i_req = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_sel !== 3'b010) begin
            errors++;
            $display("FAIL rstmid_in_access got sel=%b exp 010", o_sel);
        end
        i_rst = 1'b1; i_req = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if ({o_ready, o_err, o_rdata, o_sel, o_we, o_addr, o_wdata} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got rdy=%b err=%b rd=%h sel=%b we=%b addr=%h wd=%h exp all 0",
                     o_ready, o_err, o_rdata, o_sel, o_we, o_addr, o_wdata);
        end
        i_rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk); #1;
            if (o_ready) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_ready got %b exp 0", seen);
        end
        drive_access(1'b0, 16'h4100, 16'h0000, 1'b0);
        checks++;
        if ({ready_at, obs_rdata[3]} !== {32'd3, mem[1]}) begin
            errors++;
            $display("FAIL rstmid_recover got lat=%0d rd=%h exp 3 %h", ready_at, obs_rdata[3], mem[1]);
        end
    endtask

    task automatic test_random();
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, exp_rd;
        int            idx, exp_lat;
        bit            mp, exp_we, exp_rdy, exp_err;
        logic [NS-1:0] exp_sel;
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom); addr = AW'($urandom); wd = DW'($urandom);
            load_mem();
            drive_access(we, addr, wd, (n % 2) == 1);
            idx = int'(addr[AW-1 -: SB]);
            mp = idx < NS;
            exp_lat = mp ? WS + 2 : 1;
            checks++;
            if (ready_at !== exp_lat) begin
                errors++;
                $display("FAIL rand_latency #%0d addr %h got %0d exp %0d", n, addr, ready_at, exp_lat);
            end
            for (int j = 1; j <= ready_at; j++) begin
                exp_sel = (mp && j <= WS + 1) ? NS'(1 << idx) : '0;
                exp_we  = mp && (j == WS + 1) && we;
                exp_rdy = (j == exp_lat);
                exp_err = !mp && (j == exp_lat);
                checks++;
                if ({obs_sel[j], obs_we[j], obs_ready[j], obs_err[j]} !== {exp_sel, exp_we, exp_rdy, exp_err}) begin
                    errors++;
                    $display("FAIL rand_ctrl #%0d cyc %0d got sel=%b we=%b rdy=%b err=%b exp %b %b %b %b",
                             n, j, obs_sel[j], obs_we[j], obs_ready[j], obs_err[j],
                             exp_sel, exp_we, exp_rdy, exp_err);
                end
                if (mp && j <= WS + 1) begin
                    checks++;
                    if ({obs_addr[j], obs_wdata[j]} !== {addr[LW-1:0], wd}) begin
                        errors++;
                        $display("FAIL rand_bus #%0d cyc %0d got addr=%h wd=%h exp %h %h",
                                 n, j, obs_addr[j], obs_wdata[j], addr[LW-1:0], wd);
                    end
                end
                if (j == exp_lat) begin
                    exp_rd = (mp && !we) ? mem[idx] : '0;
                    checks++;
                    if (obs_rdata[j] !== exp_rd) begin
                        errors++;
                        $display("FAIL rand_rdata #%0d got %h exp %h", n, obs_rdata[j], exp_rd);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        load_mem();
        i_we = 1'b0; i_addr = 16'h4002; i_req = 1'b1;
        t1 = 0; t2 = 0;
        @(posedge i_clk); #1;
        for (int c = 1; c <= 30 && t2 == 0; c++) begin
            if (o_ready) begin
                if (t1 == 0) t1 = c;
                else t2 = c;
            end
            if (t2 == 0) begin
                @(posedge i_clk); #1;
            end
        end
        checks++;
        if (t1 !== WS + 2) begin
            errors++;
            $display("FAIL b2b_first got %0d exp %0d", t1, WS + 2);
        end
        checks++;
        if (t2 - t1 !== WS + 3) begin
            errors++;
            $display("FAIL b2b_gap got %0d exp %0d", t2 - t1, WS + 3);
        end
        checks++;
        if (o_rdata !== mem[1]) begin
            errors++;
            $display("FAIL b2b_rdata got %h exp %h", o_rdata, mem[1]);
        end
        i_req = 1'b0;
        @(posedge i_clk); #1;
    endtask

`ifdef DBUS_SLAVE_WAIT_EN
    task automatic test_wait();
        int  cyc;
        bit  we_seen;
        load_mem();
        i_wait = '0;
        i_we = 1'b0; i_addr = 16'h0004; i_req = 1'b1;
        @(posedge i_clk); #1;
        cyc = 1;
        while (!o_ready && cyc < MAXC) begin
            i_wait[0] = (cyc >= 2 && cyc <= 4);
            @(posedge i_clk); #1;
            cyc++;
        end
        checks++;
        if ({cyc, o_err, o_rdata} !== {32'd6, 1'b0, mem[0]}) begin
            errors++;
            $display("FAIL wait3 got lat=%0d err=%b rd=%h exp 6 0 %h", cyc, o_err, o_rdata, mem[0]);
        end
        i_req = 1'b0; i_wait = '0;
        @(posedge i_clk); #1;

        i_wait[0] = 1'b1;
        i_we = 1'b1; i_addr = 16'h0008; i_req = 1'b1;
        @(posedge i_clk); #1;
        cyc = 1; we_seen = 1'b0;
        while (!o_ready && cyc < MAXC) begin
            if (o_we) we_seen = 1'b1;
            @(posedge i_clk); #1;
            cyc++;
        end
        checks++;
        if ({cyc, o_err, o_rdata, we_seen} !== {32'd17, 1'b1, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL wait_timeout got lat=%0d err=%b rd=%h we_seen=%b exp 17 1 0000 0",
                     cyc, o_err, o_rdata, we_seen);
        end
        i_req = 1'b0; i_wait = '0;
        @(posedge i_clk); #1;
    endtask
`endif

    initial begin
        i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_rdata = '0;
`ifdef DBUS_SLAVE_WAIT_EN
        i_wait = '0;
`endif
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_latch();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef DBUS_SLAVE_WAIT_EN
        test_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
